// File: rtl/nn_buf_pkg.sv
// Shared defaults for the neural-network activation buffers.
// Holds default sizing constants and a bank-pointer width helper safe for NBANK=1.
package nn_buf_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH  = 784;
  localparam int DEF_NBANK  = 2;

  function automatic int bank_ptr_width(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/bank_ring_ctrl.sv
// Ring controller for the bank buffer: write/read pointers, committed-frame count,
// per-frame lengths, sticky error flags and per-bank RAM enable/address selects.
module bank_ring_ctrl
  import nn_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NBANK  = 2,
  parameter int AWIDTH = 2,
  parameter int LWIDTH = 3,
  parameter int BWIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_valid,
  input  logic                         w_last,
  input  logic                         r_request,
  output logic                         w_ready,
  output logic                         r_avail,
  output logic                         r_accept,
  output logic                         r_release,
  output logic [BWIDTH-1:0]            rd_bank,
  output logic [NBANK-1:0]             bank_en,
  output logic [NBANK-1:0]             bank_we,
  output logic [NBANK-1:0][AWIDTH-1:0] bank_addr,
  output logic [LWIDTH-1:0]            frame_len,
  output logic [BWIDTH:0]              bank_count,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  logic [BWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  logic [BWIDTH:0]   count_q, count_d;
  logic [LWIDTH-1:0] len_q [NBANK];
  logic              err_ovf_q, err_unf_q;
  logic              w_accept, w_commit;

  function automatic logic [BWIDTH-1:0] ptr_inc(input logic [BWIDTH-1:0] p);
    return (p == BWIDTH'(NBANK - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_ready   = count_q < (BWIDTH+1)'(NBANK);
  assign r_avail   = count_q != '0;
  assign w_accept  = w_valid && w_ready;
  assign r_accept  = r_request && r_avail;
  assign w_commit  = w_accept && (w_last || w_addr_q == AWIDTH'(DEPTH - 1));
  assign r_release = r_accept && (LWIDTH'(r_addr_q) + LWIDTH'(1) == len_q[rd_ptr_q]);

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    w_addr_d = w_addr_q;
    r_addr_d = r_addr_q;
    count_d  = count_q;
    if (w_accept)  w_addr_d = w_commit ? '0 : w_addr_q + 1'b1;
    if (w_commit)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (r_accept)  r_addr_d = r_release ? '0 : r_addr_q + 1'b1;
    if (r_release) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({w_commit, r_release})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      w_addr_q  <= '0;
      r_addr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      for (int i = 0; i < NBANK; i++) len_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      w_addr_q  <= w_addr_d;
      r_addr_q  <= r_addr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_q | (w_valid & ~w_ready);
      err_unf_q <= err_unf_q | (r_request & ~r_avail);
      if (w_commit) len_q[wr_ptr_q] <= LWIDTH'(w_addr_q) + LWIDTH'(1);
    end
  end

  // The write bank is always uncommitted and the read bank committed, so they never collide.
  always_comb begin
    bank_en   = '0;
    bank_we   = '0;
    bank_addr = '0;
    for (int i = 0; i < NBANK; i++) begin
      bank_we[i]   = w_accept && (wr_ptr_q == BWIDTH'(i));
      bank_en[i]   = (w_accept && (wr_ptr_q == BWIDTH'(i))) ||
                     (r_accept && (rd_ptr_q == BWIDTH'(i)));
      bank_addr[i] = (w_accept && (wr_ptr_q == BWIDTH'(i))) ? w_addr_q : r_addr_q;
    end
  end

  assign rd_bank       = rd_ptr_q;
  assign frame_len     = r_avail ? len_q[rd_ptr_q] : '0;
  assign bank_count    = count_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: rtl/spram.sv
// Single-port RAM with registered read; a write cycle leaves the read register untouched.
module spram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 784
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // NOTE: the array and its read register have no reset; RAM macros cannot be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= din;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign dout = rdata_q;

endmodule

// File: rtl/multibank_pingpong.sv
// N-bank ring of single-port RAM frames between a producer and a consumer.
// Reads return two cycles after acceptance: RAM read register, then output register.
module multibank_pingpong
  import nn_buf_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NBANK  = DEF_NBANK,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int LWIDTH = $clog2(DEPTH + 1),
  parameter int BWIDTH = bank_ptr_width(NBANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  input  logic              w_last,
  input  logic [DWIDTH-1:0] din,
  output logic              w_ready,
  input  logic              r_request,
  output logic              r_avail,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_dout,
  output logic              o_last,
  output logic [LWIDTH-1:0] frame_len,
  output logic [BWIDTH:0]   bank_count,
  output logic              err_overflow,
  output logic              err_underflow
);

  logic [NBANK-1:0]             bank_en, bank_we;
  logic [NBANK-1:0][AWIDTH-1:0] bank_addr;
  logic [DWIDTH-1:0]            bank_rdata [NBANK];
  logic                         r_accept, r_release;
  logic [BWIDTH-1:0]            rd_bank;

  logic              s1_valid_q, s1_last_q;
  logic [BWIDTH-1:0] s1_bank_q;
  logic              o_valid_q, o_last_q;
  logic [DWIDTH-1:0] o_dout_q;

  bank_ring_ctrl #(
    .DEPTH (DEPTH),
    .NBANK (NBANK),
    .AWIDTH(AWIDTH),
    .LWIDTH(LWIDTH),
    .BWIDTH(BWIDTH)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .w_valid      (w_valid),
    .w_last       (w_last),
    .r_request    (r_request),
    .w_ready      (w_ready),
    .r_avail      (r_avail),
    .r_accept     (r_accept),
    .r_release    (r_release),
    .rd_bank      (rd_bank),
    .bank_en      (bank_en),
    .bank_we      (bank_we),
    .bank_addr    (bank_addr),
    .frame_len    (frame_len),
    .bank_count   (bank_count),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    spram #(
      .DWIDTH(DWIDTH),
      .AWIDTH(AWIDTH),
      .DEPTH (DEPTH)
    ) u_ram (
      .clk (clk),
      .en  (bank_en[g]),
      .we  (bank_we[g]),
      .addr(bank_addr[g]),
      .din (din),
      .dout(bank_rdata[g])
    );
  end

  // Stage 1 tracks which bank's read register carries the word; stage 2 registers the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bank_q  <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_dout_q   <= '0;
    end else begin
      s1_valid_q <= r_accept;
      s1_last_q  <= r_release;
      s1_bank_q  <= rd_bank;
      o_valid_q  <= s1_valid_q;
      o_last_q   <= s1_valid_q & s1_last_q;
      if (s1_valid_q) o_dout_q <= bank_rdata[s1_bank_q];
    end
  end

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_dout  = o_dout_q;

endmodule

// File: tb/tb_multibank_pingpong.sv
// Scoreboard bench for multibank_pingpong (NBANK=3, DEPTH=4): a frame-queue model predicts
// handshakes, flags and read data; a monitor compares each output word and its arrival cycle.
module tb_multibank_pingpong;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NBANK = 3;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int BW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, w_last, r_request;
  logic [DW-1:0] din;
  logic          w_ready, r_avail, o_valid, o_last;
  logic [DW-1:0] o_dout;
  logic [LW-1:0] frame_len;
  logic [BW:0]   bank_count;
  logic          err_overflow, err_underflow;

  multibank_pingpong #(.DWIDTH(DW), .DEPTH(DEPTH), .NBANK(NBANK)) dut (
    .clk          (clk),
    .rst          (rst),
    .w_valid      (w_valid),
    .w_last       (w_last),
    .din          (din),
    .w_ready      (w_ready),
    .r_request    (r_request),
    .r_avail      (r_avail),
    .o_valid      (o_valid),
    .o_dout       (o_dout),
    .o_last       (o_last),
    .frame_len    (frame_len),
    .bank_count   (bank_count),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: committed words in order, committed frame lengths, open frame.
  typedef struct {
    int d;
    bit l;
    int due;
  } exp_t;

  int   m_data[$];
  int   m_len[$];
  int   m_part[$];
  int   m_off = 0;
  bit   m_ovf = 0;
  bit   m_unf = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic model_clear();
    m_data.delete();
    m_len.delete();
    m_part.delete();
    m_off = 0;
    m_ovf = 0;
    m_unf = 0;
    sb.delete();
  endtask

  task automatic step(input bit wv, input bit wl, input logic [DW-1:0] d, input bit rr);
    bit   wr_ok, rd_ok;
    exp_t e;
    @(negedge clk);
    check("w_ready", w_ready, m_len.size() < NBANK);
    check("r_avail", r_avail, m_len.size() > 0);
    check("bank_count", bank_count, m_len.size());
    check("frame_len", frame_len, (m_len.size() > 0) ? m_len[0] : 0);
    check("err_overflow", err_overflow, m_ovf);
    check("err_underflow", err_underflow, m_unf);
    w_valid   = wv;
    w_last    = wl;
    din       = d;
    r_request = rr;
    wr_ok = m_len.size() < NBANK;
    rd_ok = m_len.size() > 0;
    if (rr) begin
      if (rd_ok) begin
        e.d = m_data.pop_front();
        m_off++;
        e.l = (m_off == m_len[0]);
        if (e.l) begin
          void'(m_len.pop_front());
          m_off = 0;
        end
        e.due = cyc + 2;
        sb.push_back(e);
      end else m_unf = 1;
    end
    if (wv) begin
      if (wr_ok) begin
        m_part.push_back(int'(d));
        if (wl || m_part.size() == DEPTH) begin
          foreach (m_part[i]) m_data.push_back(m_part[i]);
          m_len.push_back(m_part.size());
          m_part.delete();
        end
      end else m_ovf = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_dout", o_dout, 0);
    check("rst_o_last", o_last, 0);
    check("rst_bank_count", bank_count, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_r_avail", r_avail, 0);
    check("rst_w_ready", w_ready, 1);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_underflow", err_underflow, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    w_valid = 0; w_last = 0; r_request = 0; din = '0;
    model_clear();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_len.size() > 0; k++) step(0, 0, '0, 1);
    idle(3);
  endtask

  // Monitor: every presented word must be the next expected one, on its due cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (o_valid) begin
        if (sb.size() == 0) check("unexpected_o_valid", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("o_dout", o_dout, mon_e.d);
          check("o_last", o_last, mon_e.l);
          check("read_latency", cyc, mon_e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("o_valid_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    w_valid = 0; w_last = 0; r_request = 0; din = '0;
    #12;
    check_reset_outputs();
    #10;
    rst = 1'b1;

    // Underflow on an empty ring: flag sets, nothing is returned.
    step(0, 0, '0, 1);
    idle(3);

    // Full frame without w_last, then back-to-back readback.
    for (int i = 1; i <= 4; i++) step(1, 0, DW'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
    idle(3);

    // Short frame terminated by w_last.
    step(1, 0, 8'd10, 0);
    step(1, 1, 8'd20, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    idle(3);

    // Fill every bank, then a rejected write must leave the frames intact.
    for (int f = 0; f < NBANK; f++)
      for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(100 + 10 * f + i), 0);
    step(1, 0, 8'hEE, 0);
    step(1, 1, 8'hEF, 0);
    drain();

    // Release of frame A coincides with commit of frame C.
    step(1, 0, 8'h41, 0);
    step(1, 1, 8'h42, 0);
    step(1, 0, 8'h43, 0);
    step(1, 1, 8'h44, 0);
    step(1, 0, 8'h51, 1);
    step(1, 1, 8'h52, 1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 9) == 0, DW'($urandom), $urandom_range(0, 99) < 55);
    drain();

    // Reset in the middle of a write and of a read, then a fresh frame.
    for (int i = 0; i < 4; i++) step(1, 0, DW'(8'hA0 + i), 0);
    step(1, 0, 8'hB0, 1);
    step(1, 0, 8'hB1, 1);
    async_reset();
    step(1, 0, 8'hC1, 0);
    step(1, 0, 8'hC2, 0);
    step(1, 1, 8'hC3, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    idle(3);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
